touch_lock: RTL and testbench

TOUCH_LOCK -- requirements
Module: touch_lock

---
 rtl/touch_lock.sv | 193 +++++++++++++++++++
 tb/tb_touch_lock.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/touch_lock.sv
// rtl/touch_lock.sv - debounced touch sampler with frame-synchronised coordinate lock
// Optional TOUCH_LOCK_AVG_EN: average four pressed TRACK samples before updating pending.
module touch_lock #(
  parameter int         SAMPLE_DIV = 100000,
  parameter logic [8:0] Z_THRESH   = 9'd16,
  parameter int         DEBOUNCE_N = 4
) (
  input  logic       cclk,
  input  logic       rstb,
  input  logic [8:0] touch_x,
  input  logic [8:0] touch_y,
  input  logic [8:0] touch_z,
  input  logic       new_frame,
  output logic [8:0] locked_touch_x,
  output logic [8:0] locked_touch_y,
  output logic       touch_valid,
  output logic       pen_down
);

  localparam int         TW   = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [3:0] DB_N = 4'(DEBOUNCE_N);

  typedef enum logic [1:0] {IDLE, PRESS_DB, TRACK, REL_DB} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic            pressed;
  logic            capture;
  logic            cap_valid;
  logic [8:0]      cap_x;
  logic [8:0]      cap_y;
  logic [8:0]      pending_x;
  logic [8:0]      pending_y;
  logic            pending_valid;
  logic [2:0]      frame_sync;
  logic            frame_edge;

  assign tick    = (tick_cnt == TW'(SAMPLE_DIV - 1));
  assign pressed = (touch_z > Z_THRESH);
  // Capture uses the state before this tick, so the entry tick into TRACK never captures.
  assign capture = tick && pressed && (state == TRACK);

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      pen_down <= 1'b0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (pressed) begin
            if (DB_N == 4'd1) begin
              state    <= TRACK;
              cnt      <= 4'd0;
              pen_down <= 1'b1;
            end else begin
              state <= PRESS_DB;
              cnt   <= 4'd1;
            end
          end
        end
        PRESS_DB: begin
          if (!pressed) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt + 4'd1 == DB_N) begin
            state    <= TRACK;
            cnt      <= 4'd0;
            pen_down <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        TRACK: begin
          if (!pressed) begin
            if (DB_N == 4'd1) begin
              state    <= IDLE;
              cnt      <= 4'd0;
              pen_down <= 1'b0;
            end else begin
              state <= REL_DB;
              cnt   <= 4'd1;
            end
          end
        end
        REL_DB: begin
          if (pressed) begin
            state <= TRACK;
            cnt   <= 4'd0;
          end else if (cnt + 4'd1 == DB_N) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            pen_down <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= 4'd0;
          pen_down <= 1'b0;
        end
      endcase
    end
  end

`ifdef TOUCH_LOCK_AVG_EN
  logic [10:0] sum_x;
  logic [10:0] sum_y;
  logic [1:0]  acc_n;
  logic [10:0] total_x;
  logic [10:0] total_y;

  assign total_x   = sum_x + 11'(touch_x);
  assign total_y   = sum_y + 11'(touch_y);
  assign cap_valid = capture && (acc_n == 2'd3);
  assign cap_x     = total_x[10:2];
  assign cap_y     = total_y[10:2];

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      sum_x <= '0;
      sum_y <= '0;
      acc_n <= '0;
    end else if (state != TRACK || cap_valid) begin
      sum_x <= '0;
      sum_y <= '0;
      acc_n <= '0;
    end else if (capture) begin
      sum_x <= total_x;
      sum_y <= total_y;
      acc_n <= acc_n + 2'd1;
    end
  end
`else
  assign cap_valid = capture;
  assign cap_x     = touch_x;
  assign cap_y     = touch_y;
`endif

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      frame_sync <= '0;
    end else begin
      frame_sync <= {frame_sync[1:0], new_frame};
    end
  end

  assign frame_edge = frame_sync[1] & ~frame_sync[2];

  // A capture coinciding with frame_edge bypasses pending so the display never shows a stale point.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      pending_x      <= '0;
      pending_y      <= '0;
      pending_valid  <= 1'b0;
      locked_touch_x <= '0;
      locked_touch_y <= '0;
      touch_valid    <= 1'b0;
    end else begin
      if (cap_valid) begin
        pending_x <= cap_x;
        pending_y <= cap_y;
      end
      if (frame_edge) begin
        if (cap_valid) begin
          locked_touch_x <= cap_x;
          locked_touch_y <= cap_y;
        end else if (pending_valid) begin
          locked_touch_x <= pending_x;
          locked_touch_y <= pending_y;
        end
        touch_valid   <= pen_down;
        pending_valid <= 1'b0;
      end else if (cap_valid) begin
        pending_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_touch_lock.sv
// tb/tb_touch_lock.sv - directed self-checking bench for touch_lock (SAMPLE_DIV=4, DEBOUNCE_N=4)
module tb_touch_lock;

  logic       cclk;
  logic       rstb;
  logic [8:0] touch_x;
  logic [8:0] touch_y;
  logic [8:0] touch_z;
  logic       new_frame;
  logic [8:0] locked_touch_x;
  logic [8:0] locked_touch_y;
  logic       touch_valid;
  logic       pen_down;

  int checks = 0;
  int errors = 0;

  touch_lock #(.SAMPLE_DIV(4), .Z_THRESH(9'd16), .DEBOUNCE_N(4)) dut (
    .cclk           (cclk),
    .rstb           (rstb),
    .touch_x        (touch_x),
    .touch_y        (touch_y),
    .touch_z        (touch_z),
    .new_frame      (new_frame),
    .locked_touch_x (locked_touch_x),
    .locked_touch_y (locked_touch_y),
    .touch_valid    (touch_valid),
    .pen_down       (pen_down)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Each sample period is four clocks; the fourth edge is the tick edge.
  task automatic ticks(input int n);
    repeat (n * 4) @(posedge cclk);
    #1;
  endtask

  task automatic frame_start();
    new_frame = 1'b1;
    repeat (2) @(posedge cclk);
    #1;
  endtask

  task automatic frame_end();
    @(posedge cclk);
    #1;
    new_frame = 1'b0;
    @(posedge cclk);
    #1;
  endtask

  // Raises new_frame so that frame_edge lands on the next tick edge.
  task automatic frame_at_tick();
    @(posedge cclk);
    #1;
    new_frame = 1'b1;
    repeat (3) @(posedge cclk);
    #1;
    new_frame = 1'b0;
  endtask

  initial begin
    rstb      = 1'b0;
    touch_x   = 9'd0;
    touch_y   = 9'd0;
    touch_z   = 9'd0;
    new_frame = 1'b0;
    repeat (2) @(posedge cclk);
    #1;
    chk("rst_x", locked_touch_x, 9'd0);
    chk("rst_y", locked_touch_y, 9'd0);
    chk("rst_valid", 9'(touch_valid), 9'd0);
    chk("rst_pen", 9'(pen_down), 9'd0);
    rstb = 1'b1;

    // Pressure equal to the threshold is not a press.
    touch_z = 9'd16;
    touch_x = 9'd100;
    touch_y = 9'd50;
    ticks(6);
    chk("z16_pen", 9'(pen_down), 9'd0);
    frame_start();
    frame_end();
    chk("z16_valid", 9'(touch_valid), 9'd0);

    touch_z = 9'd17;
    ticks(3);
    chk("db3_pen", 9'(pen_down), 9'd0);
    ticks(1);
    chk("db4_pen", 9'(pen_down), 9'd1);

`ifdef TOUCH_LOCK_AVG_EN
    touch_x = 9'd100;
    ticks(1);
    touch_x = 9'd101;
    ticks(1);
    touch_x = 9'd102;
    ticks(1);
    touch_x = 9'd104;
    ticks(1);
    chk("avg_prelock_x", locked_touch_x, 9'd0);
    frame_start();
    frame_end();
    chk("avg_lock_x", locked_touch_x, 9'd101);
    chk("avg_lock_y", locked_touch_y, 9'd50);
    chk("avg_valid", 9'(touch_valid), 9'd1);
`else
    ticks(1);
    frame_start();
    chk("early_x", locked_touch_x, 9'd0);
    frame_end();
    chk("lock_x", locked_touch_x, 9'd100);
    chk("lock_y", locked_touch_y, 9'd50);
    chk("lock_valid", 9'(touch_valid), 9'd1);

    touch_x = 9'd200;
    touch_y = 9'd60;
    frame_at_tick();
    chk("fwd_x", locked_touch_x, 9'd200);
    chk("fwd_y", locked_touch_y, 9'd60);

    touch_z = 9'd0;
    ticks(3);
    chk("rel3_pen", 9'(pen_down), 9'd1);
    touch_z = 9'd17;
    touch_x = 9'd210;
    touch_y = 9'd70;
    ticks(1);
    chk("retrack_pen", 9'(pen_down), 9'd1);
    touch_z = 9'd0;
    ticks(3);
    chk("rel3b_pen", 9'(pen_down), 9'd1);
    ticks(1);
    chk("rel4_pen", 9'(pen_down), 9'd0);
    chk("rel_valid_hold", 9'(touch_valid), 9'd1);
    frame_start();
    frame_end();
    chk("hold_x", locked_touch_x, 9'd200);
    chk("hold_y", locked_touch_y, 9'd60);
    chk("rel_valid", 9'(touch_valid), 9'd0);

    touch_z = 9'd17;
    touch_x = 9'd5;
    touch_y = 9'd6;
    ticks(5);
    frame_start();
    frame_end();
    chk("pre_rst_x", locked_touch_x, 9'd5);
    chk("pre_rst_valid", 9'(touch_valid), 9'd1);
`endif

    // Asynchronous reset in the middle of a press.
    rstb = 1'b0;
    #1;
    chk("mid_rst_x", locked_touch_x, 9'd0);
    chk("mid_rst_y", locked_touch_y, 9'd0);
    chk("mid_rst_valid", 9'(touch_valid), 9'd0);
    chk("mid_rst_pen", 9'(pen_down), 9'd0);
    rstb = 1'b1;
    ticks(3);
    chk("resume3_pen", 9'(pen_down), 9'd0);
    ticks(1);
    chk("resume4_pen", 9'(pen_down), 9'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
